// File: rtl/video2ram_f_if.sv
// Pixel stream in and line-buffer RAM write port out of video2ram_f.
// The DUT takes the slave side; the source/RAM model takes the master side.
interface video2ram_f_if;
   logic [23:0] pixel_in;
   logic        pixel_valid;
   logic        hsync_in;
   logic        vsync_in;
   logic [13:0] wraddr;
   logic [23:0] wrdata;
   logic        wren;

   modport master (
      output pixel_in, pixel_valid, hsync_in, vsync_in,
      input  wraddr, wrdata, wren
   );

   modport slave (
      input  pixel_in, pixel_valid, hsync_in, vsync_in,
      output wraddr, wrdata, wren
   );
endinterface

// File: rtl/video2ram_f.sv
// Capture-side writer: tracks input X/Y, writes the capture window into the
// line-buffer RAM in line-stride layout and flags when output may start.
module video2ram_f #(
   parameter bit HSYNC_ON_POLARITY = 1'b0,
   parameter bit VSYNC_ON_POLARITY = 1'b0,
   parameter int TRIGGER_LINES     = 2
) (
   input  logic         clock,
   input  logic         reset,
   video2ram_f_if.slave vid,
   input  logic [11:0]  h_capture_start,
   input  logic [11:0]  h_capture_end,
   input  logic [11:0]  v_capture_start,
   input  logic [11:0]  v_capture_end,
   input  logic [9:0]   buffer_line_length,
   input  logic [13:0]  ram_numwords,
   output logic         starttrigger,
   output logic [11:0]  frame_lines
);

   localparam logic [11:0] POS_MAX = 12'hFFF;
   localparam logic [11:0] TRIG    = 12'(TRIGGER_LINES);

   // stage 1: raw input samples
   logic [23:0] pix_q;
   logic        valid_q;
   logic        hs_q;
   logic        vs_q;

   // sync history of the previous valid sample, position counters
   logic        hs_act_q, hs_act_d;
   logic        vs_act_q, vs_act_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [13:0] base_q, base_d;
   logic        seen_q, seen_d;
   logic [1:0]  frames_q, frames_d;
   logic [11:0] lines_q, lines_d;
   logic        trig_q, trig_d;
   logic [11:0] flines_q, flines_d;

   // stage 2: RAM write port
   logic        wren_q, wren_d;
   logic [13:0] addr_q, addr_d;
   logic [23:0] data_q, data_d;

   logic        hs_act, vs_act;
   logic        hedge, vedge;
   logic [11:0] x_inc, y_inc;
   logic [11:0] x_cur, y_cur;
   logic [11:0] x_off;
   logic        seen_cur;
   logic        in_h, in_v, prev_in_v;
   logic        fits;
   logic        line_end;
   logic        base_wrap;
   logic        cap;

   always_comb begin
      hs_act    = (hs_q == HSYNC_ON_POLARITY);
      vs_act    = (vs_q == VSYNC_ON_POLARITY);
      hedge     = valid_q & hs_act & ~hs_act_q;
      vedge     = valid_q & vs_act & ~vs_act_q;

      x_inc     = (x_q == POS_MAX) ? POS_MAX : x_q + 12'd1;
      y_inc     = (y_q == POS_MAX) ? POS_MAX : y_q + 12'd1;
      x_cur     = hedge ? 12'd0 : x_inc;
      y_cur     = vedge ? 12'd0 : (hedge ? y_inc : y_q);
      seen_cur  = seen_q | vedge;

      in_h      = (x_cur >= h_capture_start) & (x_cur < h_capture_end);
      in_v      = (y_cur >= v_capture_start) & (y_cur < v_capture_end);
      prev_in_v = (y_q >= v_capture_start) & (y_q < v_capture_end);
      x_off     = x_cur - h_capture_start;
      fits      = x_off < {2'b00, buffer_line_length};

      // vsync wins over a coincident hsync for the line base
      line_end  = hedge & ~vedge & seen_q & prev_in_v;
      base_wrap = base_q >= (ram_numwords - {4'b0000, buffer_line_length});

      base_d = base_q;
      if (vedge)
         base_d = 14'd0;
      else if (line_end)
         base_d = base_wrap ? 14'd0 : base_q + {4'b0000, buffer_line_length};

      hs_act_d = valid_q ? hs_act : hs_act_q;
      vs_act_d = valid_q ? vs_act : vs_act_q;
      x_d      = valid_q ? x_cur  : x_q;
      y_d      = valid_q ? y_cur  : y_q;
      seen_d   = seen_cur;

      frames_d = frames_q;
      if (vedge && frames_q != 2'd2)
         frames_d = frames_q + 2'd1;

      lines_d = lines_q;
      if (line_end && frames_q == 2'd1 && lines_q < TRIG)
         lines_d = lines_q + 12'd1;

      trig_d = trig_q | (lines_q >= TRIG);

      flines_d = flines_q;
      if (vedge && frames_q != 2'd0)
         flines_d = y_inc;

      cap    = valid_q & seen_cur & in_h & in_v & fits;
      wren_d = cap;
      addr_d = cap ? base_d + {2'b00, x_off} : addr_q;
      data_d = cap ? {pix_q[7:0], pix_q[15:8], pix_q[23:16]} : data_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pix_q    <= '0;
         valid_q  <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         hs_act_q <= 1'b0;
         vs_act_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         base_q   <= '0;
         seen_q   <= 1'b0;
         frames_q <= '0;
         lines_q  <= '0;
         trig_q   <= 1'b0;
         flines_q <= '0;
         wren_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         pix_q    <= vid.pixel_in;
         valid_q  <= vid.pixel_valid;
         hs_q     <= vid.hsync_in;
         vs_q     <= vid.vsync_in;
         hs_act_q <= hs_act_d;
         vs_act_q <= vs_act_d;
         x_q      <= x_d;
         y_q      <= y_d;
         base_q   <= base_d;
         seen_q   <= seen_d;
         frames_q <= frames_d;
         lines_q  <= lines_d;
         trig_q   <= trig_d;
         flines_q <= flines_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign vid.wren     = wren_q;
   assign vid.wraddr   = addr_q;
   assign vid.wrdata   = data_q;
   assign starttrigger = trig_q;
   assign frame_lines  = flines_q;

endmodule
